apb_master_bridge: RTL

- Single-outstanding APB initiator that converts a simple valid/ready command channel into APB SETUP/ACCESS transfers and returns a read/write response.
- Used by test controllers and embedded sequencers to drive the APB peripheral slaves (7-segment display, resets, etc.) without a core.
- Pairs with existing slaves that assert pready_o/pslverr_o during ACCESS.

---
 rtl/apb_master_pkg.sv | 18 +
 rtl/apb_timeout_cnt.sv | 32 +++
 rtl/apb_master_bridge.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and widths for the APB master bridge and its timeout counter.
// Latency: none (declarations only). Backpressure: not applicable.
// Optional feature macro used by the bridge: APB_TIMEOUT_EN.
package apb_master_pkg;

    localparam int APB_ADDR_W    = 32;
    localparam int APB_DATA_W    = 32;
    localparam int APB_STRB_W    = 4;
    localparam int TIMEOUT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase stall counter: flags the cycle in which the count would reach the limit.
// Latency: expired flag is combinational on the current count and enable.
// Backpressure: none; counts only while enabled, clear wins over enable.
module apb_timeout_cnt
    import apb_master_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic [TIMEOUT_CNT_W-1:0] i_limit,
    output logic                     o_expired
);

    logic [TIMEOUT_CNT_W-1:0] r_cnt;
    logic [TIMEOUT_CNT_W:0]   w_cnt_nxt;

    // One extra bit so a limit of 255 can never wrap into a false match
    assign w_cnt_nxt = {1'b0, r_cnt} + {{TIMEOUT_CNT_W{1'b0}}, 1'b1};
    assign o_expired = i_en && (w_cnt_nxt == {1'b0, i_limit});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_cnt_nxt[TIMEOUT_CNT_W-1:0];
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding valid/ready command to APB SETUP/ACCESS initiator; APB_TIMEOUT_EN adds an ACCESS abort.
// Latency: accept at N, psel N+1, penable N+2, rsp_valid N+3 plus one cycle per wait state.
// Backpressure: req_ready only in IDLE; response held until rsp_ready_i, no pipelining.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk_i,
    input  logic                  presetn_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [APB_ADDR_W-1:0] req_addr_i,
    input  logic                  req_write_i,
    input  logic [APB_DATA_W-1:0] req_wdata_i,
    input  logic [APB_STRB_W-1:0] req_strb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [APB_DATA_W-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [APB_ADDR_W-1:0] paddr_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [APB_DATA_W-1:0] pwdata_o,
    output logic [APB_STRB_W-1:0] pstrb_o,
    input  logic                  pready_i,
    input  logic [APB_DATA_W-1:0] prdata_i,
    input  logic                  pslverr_i
);

    apb_mst_state_t        r_state;
    apb_mst_state_t        w_state_nxt;
    logic [APB_ADDR_W-1:0] r_addr;
    logic [APB_DATA_W-1:0] r_wdata;
    logic [APB_DATA_W-1:0] r_rdata;
    logic [APB_STRB_W-1:0] r_strb;
    logic                  r_write;
    logic                  r_err;
    logic                  w_accept;
    logic                  w_aligned;
    logic                  w_timeout;

    assign w_accept  = (r_state == IDLE) && req_valid_i;
    assign w_aligned = (req_addr_i[1:0] == 2'b00);

`ifdef APB_TIMEOUT_EN
    apb_timeout_cnt u_timeout_cnt (
        .i_clk     (pclk_i),
        .i_rst_n   (presetn_i),
        .i_clr     (r_state == SETUP),
        .i_en      ((r_state == ACCESS) && !pready_i),
        .i_limit   (TIMEOUT_CNT_W'(TIMEOUT_CYCLES)),
        .o_expired (w_timeout)
    );
`else
    logic w_unused_timeout_cycles;
    assign w_unused_timeout_cycles = |TIMEOUT_CYCLES;
    assign w_timeout               = 1'b0;
`endif

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = 1'b0;
        psel_o      = 1'b0;
        penable_o   = 1'b0;
        rsp_valid_o = 1'b0;
        case (r_state)
            IDLE: begin
                // Gated by reset so ready stays low while presetn_i is held
                req_ready_o = presetn_i;
                if (req_valid_i) begin
                    w_state_nxt = w_aligned ? SETUP : RESP;
                end
            end
            SETUP: begin
                psel_o      = 1'b1;
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                if (pready_i || w_timeout) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_write <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr_i;
                r_wdata <= req_wdata_i;
                r_strb  <= req_strb_i;
                r_write <= req_write_i;
                if (!w_aligned) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
            end
            // A slave completion in the limit cycle beats the timeout abort
            if (r_state == ACCESS) begin
                if (pready_i) begin
                    r_err   <= pslverr_i;
                    r_rdata <= (!r_write && !pslverr_i) ? prdata_i : '0;
                end else if (w_timeout) begin
                    r_err   <= 1'b1;
                    r_rdata <= '0;
                end
            end
        end
    end

    assign paddr_o     = r_addr;
    assign pwrite_o    = r_write;
    assign pwdata_o    = r_wdata;
    assign pstrb_o     = r_write ? r_strb : '0;
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;

endmodule
